vx_counting_scoreboard: RTL and testbench

Next-generation issue scoreboard that sits between the per-warp instruction buffers and operand collection. It replaces single-bit in-use flags with per-register pending-write counters, so several writes to the same destination can be in flight. It supports a configurable number of source operands and writeback ports, and selectable WAW blocking. It stages one instruction per warp, checks its hazards, and round-robin arbitrates ready warps onto one issue port.

---
 rtl/vx_counting_scoreboard.sv | 159 +++++++++++++++
 tb/tb_vx_counting_scoreboard.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_counting_scoreboard.sv
// rtl/vx_counting_scoreboard.sv - per-warp staging, counting hazard scoreboard and round-robin issue
// Pending-write counters per (warp, reg) let several writes to one rd be in flight at once.
module vx_counting_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64,
    parameter int NUM_SRCS  = 3,
    parameter int NUM_WB    = 2,
    parameter int CTR_W     = 2,
    parameter int WAW_BLOCK = 0,
    parameter int DATAW     = 64,
    parameter int PERF_W    = 32,
    localparam int RW = $clog2(NUM_REGS),
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WARPS-1:0]            in_valid,
    output logic [NUM_WARPS-1:0]            in_ready,
    input  logic [NUM_WARPS-1:0]            in_wb,
    input  logic [NUM_WARPS*RW-1:0]         in_rd,
    input  logic [NUM_WARPS*NUM_SRCS*RW-1:0] in_rs,
    input  logic [NUM_WARPS*DATAW-1:0]      in_data,
    input  logic [NUM_WB-1:0]               wb_valid,
    input  logic [NUM_WB*WW-1:0]            wb_wid,
    input  logic [NUM_WB*RW-1:0]            wb_rd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WW-1:0]                   out_wid,
    output logic [RW-1:0]                   out_rd,
    output logic                            out_wb,
    output logic [DATAW-1:0]                out_data,
    output logic                            wb_err,
    output logic [PERF_W-1:0]               perf_stalls
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [NUM_WARPS-1:0] slot_vld_q, slot_vld_d, slot_wb_q;
    logic [RW-1:0]        slot_rd_q   [NUM_WARPS];
    logic [RW-1:0]        slot_rs_q   [NUM_WARPS][NUM_SRCS];
    logic [DATAW-1:0]     slot_data_q [NUM_WARPS];
    logic [CTR_W-1:0]     ctr_q [NUM_WARPS][NUM_REGS];
    logic [CTR_W-1:0]     ctr_d [NUM_WARPS][NUM_REGS];
    logic [WW-1:0]        ptr_q, ptr_d;
    logic                 wb_err_q, wb_err_d;
    logic [PERF_W-1:0]    perf_q, perf_d;

    logic [NUM_WARPS-1:0] busy, elig, iss_oh, accept;
    logic                 gnt_vld, fire, stall;
    logic [WW-1:0]        gnt_wid, cand;

    // Hazards read only registered counters, so a writeback frees its register one cycle later.
    always_comb begin
        busy = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (ctr_q[w][slot_rs_q[w][s]] != '0) busy[w] = 1'b1;
            end
            if (slot_wb_q[w]) begin
                if (ctr_q[w][slot_rd_q[w]] == CTR_MAX) busy[w] = 1'b1;
                if (WAW_BLOCK != 0 && ctr_q[w][slot_rd_q[w]] != '0) busy[w] = 1'b1;
            end
        end
    end

    assign elig = slot_vld_q & ~busy;

    // Scan from the farthest candidate back so the nearest one after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_wid = '0;
        cand    = '0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            cand = WW'((int'(ptr_q) + k) % NUM_WARPS);
            if (elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_wid = cand;
            end
        end
    end

    assign out_valid = gnt_vld;
    assign out_wid   = gnt_wid;
    assign out_rd    = slot_rd_q[gnt_wid];
    assign out_wb    = slot_wb_q[gnt_wid];
    assign out_data  = slot_data_q[gnt_wid];
    assign fire      = gnt_vld & out_ready;

    always_comb begin
        iss_oh = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            iss_oh[w] = fire && (gnt_wid == WW'(w));
        end
    end

    assign in_ready   = ~slot_vld_q | iss_oh;
    assign accept     = in_valid & in_ready;
    assign slot_vld_d = (slot_vld_q & ~iss_oh) | accept;
    assign ptr_d      = fire ? gnt_wid : ptr_q;
    assign stall      = (|slot_vld_q) & ~(|elig);
    assign perf_d     = perf_q + PERF_W'(stall);

    // Net update: +1 on issue, -1 per matching writeback port, clamped at zero on underflow.
    always_comb begin
        int nxt;
        nxt      = 0;
        wb_err_d = wb_err_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                nxt = int'(ctr_q[w][r]);
                if (fire && out_wb && gnt_wid == WW'(w) && out_rd == RW'(r)) nxt = nxt + 1;
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid[p] && wb_wid[p*WW +: WW] == WW'(w) && wb_rd[p*RW +: RW] == RW'(r)) begin
                        nxt = nxt - 1;
                    end
                end
                if (nxt < 0) begin
                    nxt      = 0;
                    wb_err_d = 1'b1;
                end
                ctr_d[w][r] = CTR_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) ctr_q[w][r] <= '0;
            end
            slot_vld_q <= '0;
            ptr_q      <= WW'(NUM_WARPS - 1);
            wb_err_q   <= 1'b0;
            perf_q     <= '0;
        end else begin
            ctr_q      <= ctr_d;
            slot_vld_q <= slot_vld_d;
            ptr_q      <= ptr_d;
            wb_err_q   <= wb_err_d;
            perf_q     <= perf_d;
        end
    end

    // Slot payload is qualified by slot_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (accept[w]) begin
                slot_wb_q[w]   <= in_wb[w];
                slot_rd_q[w]   <= in_rd[w*RW +: RW];
                slot_data_q[w] <= in_data[w*DATAW +: DATAW];
                for (int s = 0; s < NUM_SRCS; s++) begin
                    slot_rs_q[w][s] <= in_rs[(w*NUM_SRCS+s)*RW +: RW];
                end
            end
        end
    end

    assign wb_err      = wb_err_q;
    assign perf_stalls = perf_q;
endmodule

// File: tb/tb_vx_counting_scoreboard.sv
// tb/tb_vx_counting_scoreboard.sv - vector table, corner sequences and random run against a reference model
module tb_vx_counting_scoreboard;
    localparam int NW = 4, NR = 64, NS = 3, NB = 2, CW = 2, WAW = 0, DW = 64, PW = 32;
    localparam int RW = 6, WW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NW-1:0]     in_valid, in_ready, in_wb;
    logic [NW*RW-1:0]  in_rd;
    logic [NW*NS*RW-1:0] in_rs;
    logic [NW*DW-1:0]  in_data;
    logic [NB-1:0]     wb_valid;
    logic [NB*WW-1:0]  wb_wid;
    logic [NB*RW-1:0]  wb_rd;
    logic              out_valid, out_ready, out_wb, wb_err;
    logic [WW-1:0]     out_wid;
    logic [RW-1:0]     out_rd;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     perf_stalls;

    vx_counting_scoreboard #(
        .NUM_WARPS(NW), .NUM_REGS(NR), .NUM_SRCS(NS), .NUM_WB(NB),
        .CTR_W(CW), .WAW_BLOCK(WAW), .DATAW(DW), .PERF_W(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb(in_wb), .in_rd(in_rd),
        .in_rs(in_rs), .in_data(in_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_rd(out_rd), .out_wb(out_wb), .out_data(out_data),
        .wb_err(wb_err), .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Bench-side stimulus
    bit          b_iv [NW];
    bit          b_wb [NW];
    int          b_rd [NW];
    int          b_rs [NW][NS];
    logic [63:0] b_data [NW];
    bit          b_wbv [NB];
    int          b_wbw [NB];
    int          b_wbr [NB];
    bit          b_ordy;

    // Reference model state
    int          m_ctr [NW][NR];
    bit          m_vld [NW];
    bit          m_wb  [NW];
    int          m_rd  [NW];
    int          m_rs  [NW][NS];
    logic [63:0] m_data [NW];
    int          m_ptr;
    bit          m_err;
    logic [31:0] m_perf;
    bit          m_elig [NW];
    bit          m_rdy  [NW];
    bit          m_gv;
    int          m_gw;

    typedef struct {
        logic [3:0] iv;
        logic       iwb;
        int         rd;
        int         rs0;
        logic       wbv;
        int         wbw;
        int         wbr;
        logic       ordy;
        int         ev;
        int         ew;
        int         erdy;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_instr(input int w, input bit wb, input int rd, input int r0, input int r1, input int r2);
        b_wb[w]    = wb;
        b_rd[w]    = rd;
        b_rs[w][0] = r0;
        b_rs[w][1] = r1;
        b_rs[w][2] = r2;
        b_data[w]  = {$urandom, $urandom};
    endtask

    task automatic clear_inputs();
        for (int w = 0; w < NW; w++) begin
            b_iv[w] = 1'b0;
            set_instr(w, 1'b0, 0, 0, 0, 0);
        end
        for (int p = 0; p < NB; p++) begin
            b_wbv[p] = 1'b0;
            b_wbw[p] = 0;
            b_wbr[p] = 0;
        end
        b_ordy = 1'b1;
    endtask

    task automatic drive();
        for (int w = 0; w < NW; w++) begin
            in_valid[w]            = b_iv[w];
            in_wb[w]               = b_wb[w];
            in_rd[w*RW +: RW]      = RW'(b_rd[w]);
            in_data[w*DW +: DW]    = b_data[w];
            for (int s = 0; s < NS; s++) in_rs[(w*NS+s)*RW +: RW] = RW'(b_rs[w][s]);
        end
        for (int p = 0; p < NB; p++) begin
            wb_valid[p]          = b_wbv[p];
            wb_wid[p*WW +: WW]   = WW'(b_wbw[p]);
            wb_rd[p*RW +: RW]    = RW'(b_wbr[p]);
        end
        out_ready = b_ordy;
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_vld[w] = 1'b0;
            for (int r = 0; r < NR; r++) m_ctr[w][r] = 0;
        end
        m_ptr  = NW - 1;
        m_err  = 1'b0;
        m_perf = '0;
    endtask

    task automatic model_eval();
        for (int w = 0; w < NW; w++) begin
            m_elig[w] = m_vld[w];
            for (int s = 0; s < NS; s++) if (m_ctr[w][m_rs[w][s]] != 0) m_elig[w] = 1'b0;
            if (m_wb[w] && (m_ctr[w][m_rd[w]] == CMAX || (WAW != 0 && m_ctr[w][m_rd[w]] != 0)))
                m_elig[w] = 1'b0;
        end
        m_gv = 1'b0;
        m_gw = 0;
        for (int k = 1; k <= NW; k++) begin
            if (!m_gv && m_elig[(m_ptr + k) % NW]) begin
                m_gv = 1'b1;
                m_gw = (m_ptr + k) % NW;
            end
        end
        for (int w = 0; w < NW; w++) m_rdy[w] = !m_vld[w] || (m_gv && b_ordy && m_gw == w);
    endtask

    task automatic check_model();
        logic [3:0] er;
        model_eval();
        for (int w = 0; w < NW; w++) er[w] = m_rdy[w];
        chk("out_valid", out_valid, m_gv);
        if (m_gv) begin
            chk("out_wid", out_wid, m_gw);
            chk("out_rd", out_rd, m_rd[m_gw]);
            chk("out_wb", out_wb, m_wb[m_gw]);
            chk("out_data", out_data, m_data[m_gw]);
        end
        chk("in_ready", in_ready, er);
        chk("wb_err", wb_err, m_err);
        chk("perf_stalls", perf_stalls, m_perf);
    endtask

    task automatic model_advance();
        bit fire, anyv, anye;
        model_eval();
        fire = m_gv && b_ordy;
        anyv = 1'b0;
        anye = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (m_vld[w])  anyv = 1'b1;
            if (m_elig[w]) anye = 1'b1;
        end
        if (anyv && !anye) m_perf = m_perf + 1;
        if (fire && m_wb[m_gw]) m_ctr[m_gw][m_rd[m_gw]]++;
        for (int p = 0; p < NB; p++) if (b_wbv[p]) m_ctr[b_wbw[p]][b_wbr[p]]--;
        for (int p = 0; p < NB; p++) begin
            if (b_wbv[p] && m_ctr[b_wbw[p]][b_wbr[p]] < 0) begin
                m_ctr[b_wbw[p]][b_wbr[p]] = 0;
                m_err = 1'b1;
            end
        end
        if (fire) begin
            m_vld[m_gw] = 1'b0;
            m_ptr       = m_gw;
        end
        for (int w = 0; w < NW; w++) begin
            if (b_iv[w] && m_rdy[w]) begin
                m_vld[w]  = 1'b1;
                m_wb[w]   = b_wb[w];
                m_rd[w]   = b_rd[w];
                m_data[w] = b_data[w];
                for (int s = 0; s < NS; s++) m_rs[w][s] = b_rs[w][s];
            end
        end
    endtask

    // Called just after a rising edge; negative expectation arguments mean "don't care".
    task automatic cycle_x(input int ev, input int ew, input int ee, input int er);
        drive();
        @(negedge clk);
        if (ev >= 0) chk("seq_out_valid", out_valid, ev);
        if (ew >= 0) chk("seq_out_wid", out_wid, ew);
        if (ee >= 0) chk("seq_wb_err", wb_err, ee);
        if (er >= 0) chk("seq_in_ready", in_ready, er);
        check_model();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        drive();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 4'hf);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_perf", perf_stalls, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1'b1, 5, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};
        tbl[1]  = '{4'b0001, 1'b0, 0, 5, 1'b0, 0, 0, 1'b1, 1,  0, 15};
        tbl[2]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, -1, 14};
        tbl[3]  = '{4'b0000, 1'b0, 0, 0, 1'b1, 0, 5, 1'b1, 0, -1, 14};
        tbl[4]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  0, 15};
        tbl[5]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};
        tbl[6]  = '{4'b1111, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};
        tbl[7]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  1,  2};
        tbl[8]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  2,  6};
        tbl[9]  = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  3, 14};
        tbl[10] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  0, 15};
        tbl[11] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};
        tbl[12] = '{4'b0011, 1'b1, 3, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};
        tbl[13] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1,  1, 12};
        tbl[14] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1,  1, 12};
        tbl[15] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1,  1, 12};
        tbl[16] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  1, 14};
        tbl[17] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1,  0, 15};
        tbl[18] = '{4'b0000, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0, -1, 15};

        clear_inputs();
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // RAW, round-robin and out_ready hold from the table
        for (int i = 0; i < 19; i++) begin
            for (int w = 0; w < NW; w++) begin
                b_iv[w] = tbl[i].iv[w];
                set_instr(w, tbl[i].iwb, tbl[i].rd, tbl[i].rs0, 0, 0);
            end
            b_wbv[0] = tbl[i].wbv;
            b_wbw[0] = tbl[i].wbw;
            b_wbr[0] = tbl[i].wbr;
            b_wbv[1] = 1'b0;
            b_ordy   = tbl[i].ordy;
            cycle_x(tbl[i].ev, tbl[i].ew, -1, tbl[i].erdy);
        end

        // WAW counting to saturation on warp 1, rd 7
        clear_inputs();
        b_iv[1] = 1'b1;
        set_instr(1, 1'b1, 7, 0, 0, 0); cycle_x(0, -1, -1, -1);
        set_instr(1, 1'b1, 7, 0, 0, 0); cycle_x(1, 1, -1, -1);
        set_instr(1, 1'b1, 7, 0, 0, 0); cycle_x(1, 1, -1, -1);
        set_instr(1, 1'b1, 7, 0, 0, 0); cycle_x(1, 1, -1, -1);
        b_iv[1] = 1'b0;
        cycle_x(0, -1, -1, 13);
        cycle_x(0, -1, -1, 13);
        b_wbv[0] = 1'b1; b_wbw[0] = 1; b_wbr[0] = 7;
        cycle_x(0, -1, -1, 13);
        b_wbv[0] = 1'b0;
        cycle_x(1, 1, -1, -1);
        b_wbv[0] = 1'b1; b_wbv[1] = 1'b1; b_wbw[1] = 1; b_wbr[1] = 7;
        cycle_x(0, -1, 0, -1);
        b_wbv[1] = 1'b0;
        cycle_x(0, -1, 0, -1);

        // Dual writeback to one register: exact drain, then underflow
        clear_inputs();
        b_iv[2] = 1'b1;
        set_instr(2, 1'b1, 9, 0, 0, 0); cycle_x(0, -1, -1, -1);
        set_instr(2, 1'b1, 9, 0, 0, 0); cycle_x(1, 2, -1, -1);
        b_iv[2] = 1'b0;
        cycle_x(1, 2, -1, -1);
        b_wbv[0] = 1'b1; b_wbw[0] = 2; b_wbr[0] = 9;
        b_wbv[1] = 1'b1; b_wbw[1] = 2; b_wbr[1] = 9;
        cycle_x(0, -1, 0, -1);
        b_wbv[0] = 1'b0; b_wbv[1] = 1'b0;
        b_iv[2] = 1'b1;
        set_instr(2, 1'b1, 9, 9, 0, 0); cycle_x(0, -1, 0, -1);
        b_iv[2] = 1'b0;
        cycle_x(1, 2, 0, -1);
        b_wbv[0] = 1'b1; b_wbv[1] = 1'b1;
        cycle_x(0, -1, 0, -1);
        b_wbv[0] = 1'b0; b_wbv[1] = 1'b0;
        cycle_x(0, -1, 1, -1);

        // Issue and writeback to the same (warp, reg) in one cycle
        clear_inputs();
        b_iv[3] = 1'b1;
        set_instr(3, 1'b1, 4, 0, 0, 0); cycle_x(0, -1, -1, -1);
        set_instr(3, 1'b1, 4, 0, 0, 0); cycle_x(1, 3, -1, -1);
        set_instr(3, 1'b0, 0, 4, 0, 0);
        b_wbv[0] = 1'b1; b_wbw[0] = 3; b_wbr[0] = 4;
        cycle_x(1, 3, -1, -1);
        b_iv[3] = 1'b0; b_wbv[0] = 1'b0;
        cycle_x(0, -1, -1, -1);
        b_wbv[0] = 1'b1;
        cycle_x(0, -1, -1, -1);
        b_wbv[0] = 1'b0;
        cycle_x(1, 3, -1, -1);
        cycle_x(0, -1, -1, -1);

        // Asynchronous reset with full slots and live counters
        clear_inputs();
        for (int w = 0; w < NW; w++) begin
            b_iv[w] = 1'b1;
            set_instr(w, 1'b1, 10 + w, 0, 0, 0);
        end
        cycle_x(0, -1, -1, -1);
        for (int w = 0; w < NW; w++) set_instr(w, 1'b0, 0, 10 + w, 0, 0);
        cycle_x(1, 0, -1, -1);
        do_reset();
        b_iv[0] = 1'b1;
        set_instr(0, 1'b0, 0, 10, 5, 0);
        cycle_x(0, -1, 0, 15);
        b_iv[0] = 1'b0;
        cycle_x(1, 0, 0, -1);
        cycle_x(0, -1, 0, 15);

        // Randomised traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int w = 0; w < NW; w++) begin
                b_iv[w] = ($urandom_range(0, 1) == 1);
                set_instr(w, ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                          $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
            end
            for (int p = 0; p < NB; p++) begin
                b_wbv[p] = ($urandom_range(0, 9) < 5);
                b_wbw[p] = $urandom_range(0, 3);
                b_wbr[p] = $urandom_range(0, 7);
                if (c < 750 || $urandom_range(0, 9) != 0) begin
                    for (int t = 0; t < 16; t++) begin
                        if (m_ctr[b_wbw[p]][b_wbr[p]] == 0) begin
                            b_wbw[p] = $urandom_range(0, 3);
                            b_wbr[p] = $urandom_range(0, 7);
                        end
                    end
                end
            end
            b_ordy = ($urandom_range(0, 3) != 0);
            cycle_x(-1, -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
